// File: rtl/spi_periph_bus_bridge.sv
// SPI peripheral to byte-wide backend bus bridge.
// Takes the byte handshakes of spi_periph (data_wr/wr_done, data_req/data_rd),
// brings them into the clk_i domain, runs one backend bus cycle per byte and
// completes the handshake on acknowledge or on timeout.
module spi_periph_bus_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 255,
  parameter logic [7:0]  RD_DEFAULT  = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_cs_n,
  input  logic [15:0] spi_addr,
  input  logic [7:0]  spi_wdata,
  input  logic        spi_data_wr,
  output logic        spi_wr_done,
  input  logic        spi_data_req,
  output logic [7:0]  spi_rdata,
  output logic        spi_data_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        err_o,
  input  logic        err_clr
);

  // A zero TIMEOUT means "wait forever"; the counter is then never advanced.
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam int              TO_W    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  // The abort decision is taken in the cycle the count would reach TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    WR_BUS,
    RD_BUS,
    WR_DONE,
    RD_DONE
  } state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [TO_W-1:0]   to_cnt;
  logic              rd_pend;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   wr_s_q;
  logic                   req_s_q;

  logic wr_s;
  logic req_s;
  logic cs_s;
  logic wr_rise;
  logic rd_rise;
  logic to_hit;

  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign req_s   = req_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign wr_rise = wr_s & ~wr_s_q;
  assign rd_rise = req_s & ~req_s_q;
  assign to_hit  = TO_EN && (to_cnt == TO_LAST);

  // Synchroniser chains for the SPI-domain handshake and chip select, plus
  // the one-cycle history used for edge detection. cs_n idles deselected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_sync  <= '0;
      req_sync <= '0;
      cs_sync  <= '1;
      wr_s_q   <= 1'b0;
      req_s_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain really is SYNC_STAGES flops deep.
      wr_sync[0]  <= spi_data_wr;
      req_sync[0] <= spi_data_req;
      cs_sync[0]  <= spi_cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wr_sync[i]  <= wr_sync[i-1];
        req_sync[i] <= req_sync[i-1];
        cs_sync[i]  <= cs_sync[i-1];
      end
      wr_s_q  <= wr_s;
      req_s_q <= req_s;
    end
  end

  // Bridge sequencer: launches bus cycles, tracks timeout, drives the
  // handshake outputs and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      idx         <= 2'd0;
      to_cnt      <= '0;
      rd_pend     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 16'h0000;
      bus_wdata   <= 8'h00;
      spi_wr_done <= 1'b0;
      spi_data_rd <= 1'b0;
      spi_rdata   <= RD_DEFAULT;
      err_o       <= 1'b0;
    end else begin
      // Clear first; a timeout assigned further down in the same cycle
      // overrides it, so a simultaneous set wins.
      if (err_clr) err_o <= 1'b0;

      // A read request that arrives while busy is remembered until served,
      // withdrawn, or the host deselects.
      if (cs_s || !req_s) begin
        rd_pend <= 1'b0;
      end else if (rd_rise && (state != IDLE)) begin
        rd_pend <= 1'b1;
      end

      if (cs_s) idx <= 2'd0;

      if (cs_s && (state != IDLE)) begin
        // Host deselected mid-transfer: abandon the cycle without flagging.
        state       <= IDLE;
        bus_req     <= 1'b0;
        spi_wr_done <= 1'b0;
        spi_data_rd <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cs_s && wr_rise) begin
              state     <= WR_BUS;
              bus_req   <= 1'b1;
              bus_we    <= 1'b1;
              bus_addr  <= spi_addr + {14'd0, idx};
              bus_wdata <= spi_wdata;
              to_cnt    <= '0;
              // Write wins a tie; the read is picked up after the write.
              if (rd_rise) rd_pend <= 1'b1;
            end else if (!cs_s && req_s && (rd_rise || rd_pend)) begin
              state    <= RD_BUS;
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= spi_addr + {14'd0, idx};
              to_cnt   <= '0;
              rd_pend  <= 1'b0;
            end
          end

          WR_BUS: begin
            if (bus_ack) begin
              bus_req     <= 1'b0;
              spi_wr_done <= 1'b1;
              state       <= WR_DONE;
            end else if (to_hit) begin
              // Byte is dropped, but the host is still released.
              bus_req     <= 1'b0;
              spi_wr_done <= 1'b1;
              err_o       <= 1'b1;
              state       <= WR_DONE;
            end else if (TO_EN) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          RD_BUS: begin
            if (bus_ack) begin
              spi_rdata <= bus_rdata;
              bus_req   <= 1'b0;
              state     <= RD_DONE;
            end else if (to_hit) begin
              spi_rdata <= RD_DEFAULT;
              bus_req   <= 1'b0;
              err_o     <= 1'b1;
              state     <= RD_DONE;
            end else if (TO_EN) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          WR_DONE: begin
            if (!wr_s) begin
              spi_wr_done <= 1'b0;
              idx         <= idx + 2'd1;
              state       <= IDLE;
            end
          end

          RD_DONE: begin
            // spi_rdata was loaded on entry, so it is settled one cycle
            // before spi_data_rd rises.
            if (!req_s) begin
              spi_data_rd <= 1'b0;
              idx         <= idx + 2'd1;
              state       <= IDLE;
            end else begin
              spi_data_rd <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_periph_bus_bridge.sv
// Testbench for spi_periph_bus_bridge: plays the spi_periph host side and a
// byte-addressed backend memory, and compares against a reference model of
// the expected backend traffic and returned bytes.
module tb_spi_periph_bus_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        spi_cs_n;
  logic [15:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_data_wr;
  logic        spi_wr_done;
  logic        spi_data_req;
  logic [7:0]  spi_rdata;
  logic        spi_data_rd;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        err_o;
  logic        err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // Backend state
  bit [7:0] bk_mem  [0:65535];
  bit [7:0] ref_mem [0:65535];
  txn_t     log_q [$];
  int       ack_delay = 3;
  bit       ack_en    = 1'b1;

  spi_periph_bus_bridge #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT),
    .RD_DEFAULT (8'hFF)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .spi_cs_n    (spi_cs_n),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_data_wr (spi_data_wr),
    .spi_wr_done (spi_wr_done),
    .spi_data_req(spi_data_req),
    .spi_rdata   (spi_rdata),
    .spi_data_rd (spi_data_rd),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .err_o       (err_o),
    .err_clr     (err_clr)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backend memory: acks the ack_delay-th cycle of each request.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk_i);
      bus_ack = 1'b0;
      if (bus_req === 1'b1 && rst_ni === 1'b1) begin
        wait_cnt++;
        if (ack_en && wait_cnt >= ack_delay) begin
          if (bus_we === 1'b1) begin
            bk_mem[bus_addr] = bus_wdata;
            log_q.push_back('{1'b1, bus_addr, bus_wdata});
          end else begin
            bus_rdata = bk_mem[bus_addr];
            log_q.push_back('{1'b0, bus_addr, bk_mem[bus_addr]});
          end
          bus_ack  = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- host-side helpers (stimulus only) ----------------

  task automatic begin_txn(input logic [15:0] a);
    spi_addr = a;
    @(negedge clk_i);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic end_txn();
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk_i);
  endtask

  // ok = wr_done rose, was still high when data_wr fell, then dropped later.
  task automatic host_write(input logic [7:0] d, output bit ok);
    int n;
    ok = 1'b1;
    spi_wdata   = d;
    spi_data_wr = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (spi_wr_done !== 1'b1 && n < 300);
    if (spi_wr_done !== 1'b1) ok = 1'b0;
    spi_data_wr = 1'b0;
    if (spi_wr_done !== 1'b1) ok = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (spi_wr_done !== 1'b0 && n < 20);
    if (spi_wr_done !== 1'b0 || n < SYNC_STAGES) ok = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // ord = spi_rdata already held its final value the cycle before data_rd.
  task automatic host_read(output logic [7:0] d, output bit ok, output bit ord);
    int n;
    logic [7:0] prev;
    ok   = 1'b1;
    prev = spi_rdata;
    spi_data_req = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      n++;
      if (spi_data_rd === 1'b1) break;
      prev = spi_rdata;
    end
    if (spi_data_rd !== 1'b1) ok = 1'b0;
    d   = spi_rdata;
    ord = (prev === spi_rdata);
    spi_data_req = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (spi_data_rd !== 1'b0 && n < 20);
    if (spi_data_rd !== 1'b0) ok = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // ---------------- scenarios ----------------

  task automatic test_reset();
    rst_ni = 1'b0; spi_cs_n = 1'b1; spi_addr = '0; spi_wdata = '0;
    spi_data_wr = 1'b0; spi_data_req = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if ({bus_req, bus_we, spi_wr_done, spi_data_rd, err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/we/done/rd/err=%b want 00000",
               {bus_req, bus_we, spi_wr_done, spi_data_rd, err_o});
    end
    n_tests++;
    if ({bus_addr, bus_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0000/00", bus_addr, bus_wdata);
    end
    n_tests++;
    if (spi_rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want ff", spi_rdata);
    end
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    n_tests++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: bus_req=%b want 0 after release", bus_req);
    end
  endtask

  task automatic test_write4();
    logic [7:0] bytes [4] = '{8'h9A, 8'h35, 8'h3C, 8'h11};
    bit ok;
    log_q.delete();
    ack_delay = 3;
    begin_txn(16'h4C4C);
    for (int i = 0; i < 4; i++) begin
      host_write(bytes[i], ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL write4_handshake[%0d]: wr_done sequence wrong", i);
      end
      ref_mem[16'h4C4C + 16'(i)] = bytes[i];
    end
    end_txn();
    n_tests++;
    if (log_q.size() != 4) begin
      n_fail++;
      $display("FAIL write4_count: got %0d bus cycles want 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (log_q[i] !== txn_t'{1'b1, 16'h4C4C + 16'(i), bytes[i]}) begin
          n_fail++;
          $display("FAIL write4_cycle[%0d]: got we=%b %h=%h want we=1 %h=%h", i,
                   log_q[i].we, log_q[i].addr, log_q[i].data, 16'h4C4C + 16'(i), bytes[i]);
        end
      end
    end
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write4_err: err_o=%b want 0", err_o);
    end
  endtask

  task automatic test_read4();
    logic [7:0] src [4] = '{8'h35, 8'h57, 8'h00, 8'hFA};
    logic [31:0] word;
    logic [7:0] d;
    bit ok, ord;
    for (int i = 0; i < 4; i++) begin
      bk_mem[16'hF0F0 + 16'(i)]  = src[i];
      ref_mem[16'hF0F0 + 16'(i)] = src[i];
    end
    log_q.delete();
    word = '0;
    begin_txn(16'hF0F0);
    for (int i = 0; i < 4; i++) begin
      host_read(d, ok, ord);
      word[8*i +: 8] = d;
      n_tests++;
      if (!ok || !ord) begin
        n_fail++;
        $display("FAIL read4_handshake[%0d]: ok=%b rdata_early=%b want 1/1", i, ok, ord);
      end
    end
    end_txn();
    n_tests++;
    if (word !== 32'hFA005735) begin
      n_fail++;
      $display("FAIL read4_word: got %h want fa005735", word);
    end
    for (int i = 0; i < log_q.size(); i++) begin
      n_tests++;
      if (log_q[i].we !== 1'b0 || log_q[i].addr !== 16'hF0F0 + 16'(i)) begin
        n_fail++;
        $display("FAIL read4_cycle[%0d]: got we=%b addr=%h want we=0 addr=%h",
                 i, log_q[i].we, log_q[i].addr, 16'hF0F0 + 16'(i));
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    log_q.delete();
    begin_txn(16'hFFFF);
    host_write(8'hA1, ok);
    host_write(8'hB2, ok);
    end_txn();
    n_tests++;
    if (log_q.size() != 2 || log_q[0].addr !== 16'hFFFF || log_q[1].addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL addr_wrap: got %0d cycles first=%h second=%h want ffff,0000",
               log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 16'hxxxx,
               (log_q.size() > 1) ? log_q[1].addr : 16'hxxxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wd, rd_exp;
    int n;
    wd     = 8'($urandom);
    rd_exp = 8'($urandom);
    bk_mem[16'h3001]  = rd_exp;
    ref_mem[16'h3001] = rd_exp;
    log_q.delete();
    begin_txn(16'h3000);
    spi_wdata    = wd;
    spi_data_wr  = 1'b1;
    spi_data_req = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (spi_wr_done !== 1'b1 && n < 100);
    n_tests++;
    if (spi_wr_done !== 1'b1 || spi_data_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_write_first: wr_done=%b data_rd=%b want 1/0", spi_wr_done, spi_data_rd);
    end
    spi_data_wr = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (spi_data_rd !== 1'b1 && n < 100);
    n_tests++;
    if (spi_data_rd !== 1'b1 || spi_rdata !== ref_mem[16'h3001]) begin
      n_fail++;
      $display("FAIL tie_read_after: data_rd=%b rdata=%h want 1/%h", spi_data_rd, spi_rdata,
               ref_mem[16'h3001]);
    end
    spi_data_req = 1'b0;
    repeat (6) @(negedge clk_i);
    end_txn();
    n_tests++;
    if (log_q.size() != 2 || log_q[0] !== txn_t'{1'b1, 16'h3000, wd} ||
        log_q[1] !== txn_t'{1'b0, 16'h3001, rd_exp}) begin
      n_fail++;
      $display("FAIL tie_order: got %0d cycles want write 3000=%h then read 3001",
               log_q.size(), wd);
    end
  endtask

  task automatic test_random();
    txn_t exp_q [$];
    logic [15:0] base, a;
    logic [7:0] d, got;
    int len;
    bit is_wr, ok, ord;
    for (int t = 0; t < 10; t++) begin
      base      = 16'($urandom_range(0, 65535));
      len       = $urandom_range(1, 4);
      is_wr     = 1'($urandom_range(0, 1));
      ack_delay = $urandom_range(1, 6);
      log_q.delete();
      exp_q.delete();
      begin_txn(base);
      for (int i = 0; i < len; i++) begin
        a = 16'(32'(base) + i);
        d = 8'($urandom);
        if (is_wr) begin
          host_write(d, ok);
          ref_mem[a] = d;
          exp_q.push_back('{1'b1, a, d});
          ord = 1'b1;
        end else begin
          bk_mem[a]  = d;
          ref_mem[a] = d;
          host_read(got, ok, ord);
          exp_q.push_back('{1'b0, a, d});
          n_tests++;
          if (got !== ref_mem[a]) begin
            n_fail++;
            $display("FAIL rand_rdata[%0d.%0d]: addr %h got %h want %h", t, i, a, got, ref_mem[a]);
          end
        end
        n_tests++;
        if (!ok || !ord) begin
          n_fail++;
          $display("FAIL rand_handshake[%0d.%0d]: ok=%b ord=%b want 1/1", t, i, ok, ord);
        end
      end
      end_txn();
      n_tests++;
      if (log_q != exp_q) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: base %h len %0d we %b: %0d cycles seen, %0d expected or content differs",
                 t, base, len, is_wr, log_q.size(), exp_q.size());
      end
    end
    ack_delay = 3;
  endtask

  task automatic test_read_timeout();
    int n, t;
    logic [7:0] prev;
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_pre_err: err_o=%b want 0", err_o);
    end
    ack_en = 1'b0;
    begin_txn(16'hFF00);
    spi_data_req = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (bus_req !== 1'b1 && n < 50);
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 16'hFF00 || bus_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_launch: req=%b addr=%h we=%b want 1/ff00/0", bus_req, bus_addr, bus_we);
    end
    t = 0;
    prev = spi_rdata;
    while (spi_data_rd !== 1'b1 && t < 100) begin
      prev = spi_rdata;
      @(negedge clk_i);
      t++;
    end
    n_tests++;
    if (t != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL rto_latency: data_rd after %0d cycles want %0d", t, TIMEOUT + 1);
    end
    n_tests++;
    if (spi_rdata !== 8'hFF || prev !== 8'hFF || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rto_value: rdata=%h prev=%h err=%b want ff/ff/1", spi_rdata, prev, err_o);
    end
    spi_data_req = 1'b0;
    repeat (6) @(negedge clk_i);
    end_txn();
    ack_en = 1'b1;
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rto_sticky: err_o=%b want 1", err_o);
    end
    err_clr = 1'b1;
    @(negedge clk_i);
    err_clr = 1'b0;
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_clear: err_o=%b want 0", err_o);
    end
  endtask

  task automatic test_abort();
    int n;
    bit ok;
    ack_en = 1'b1;
    begin_txn(16'h5000);
    host_write(8'h10, ok);
    ack_en = 1'b0;
    spi_data_req = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (bus_req !== 1'b1 && n < 50);
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 16'h5001) begin
      n_fail++;
      $display("FAIL abort_launch: req=%b addr=%h want 1/5001", bus_req, bus_addr);
    end
    spi_cs_n = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (bus_req !== 1'b0 && n < 20);
    n_tests++;
    if (bus_req !== 1'b0 || n > SYNC_STAGES + 1 || spi_data_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: req=%b after %0d cycles data_rd=%b want 0 within %0d, 0",
               bus_req, n, spi_data_rd, SYNC_STAGES + 1);
    end
    spi_data_req = 1'b0;
    repeat (5) @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_err: err_o=%b want 0", err_o);
    end
    ack_en = 1'b1;
    log_q.delete();
    begin_txn(16'h5000);
    host_write(8'h42, ok);
    end_txn();
    n_tests++;
    if (log_q.size() != 1 || log_q[0] !== txn_t'{1'b1, 16'h5000, 8'h42}) begin
      n_fail++;
      $display("FAIL abort_restart: %0d cycles, want single write 5000=42", log_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    bit ok;
    ack_en = 1'b0;
    log_q.delete();
    begin_txn(16'h1234);
    host_write(8'hAB, ok);
    n_tests++;
    if (!ok || err_o !== 1'b1 || log_q.size() != 0) begin
      n_fail++;
      $display("FAIL wto: ok=%b err=%b cycles=%0d want 1/1/0", ok, err_o, log_q.size());
    end
    spi_wdata   = 8'hCD;
    spi_data_wr = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (bus_req !== 1'b1 && n < 50);
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 16'h1235) begin
      n_fail++;
      $display("FAIL rst_launch: req=%b addr=%h want 1/1235", bus_req, bus_addr);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({bus_req, spi_wr_done, err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_async: req/done/err=%b want 000", {bus_req, spi_wr_done, err_o});
    end
    spi_data_wr = 1'b0;
    spi_cs_n    = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    n_tests++;
    if (bus_req !== 1'b0 || spi_wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: req=%b done=%b want 0/0", bus_req, spi_wr_done);
    end
    ack_en = 1'b1;
    begin_txn(16'h2000);
    host_write(8'h77, ok);
    end_txn();
    n_tests++;
    if (!ok || log_q.size() != 1 || log_q[0] !== txn_t'{1'b1, 16'h2000, 8'h77}) begin
      n_fail++;
      $display("FAIL rst_resume: ok=%b cycles=%0d want write 2000=77", ok, log_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write4();
    test_read4();
    test_addr_wrap();
    test_back_to_back();
    test_random();
    test_read_timeout();
    test_abort();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
